// File: rtl/rate_tick_gen.sv
// -----------------------------------------------------------------------------
// rate_tick_gen
//   Programmable rate divider. Produces a single-cycle enable pulse (tick) once
//   every rate+1 enabled CLOCK_50 cycles, a square wave that toggles on each
//   tick, and a wrapping count of ticks. Downstream logic must qualify on tick
//   while staying on CLOCK_50; square is for observation only, never a clock.
//
// Ports
//   CLOCK_50    in   1      system clock, rising edge
//   resetn      in   1      asynchronous active-low reset
//   enable      in   1      count enable; low pauses the counter
//   load        in   1      capture rate_in as the new rate and restart phase
//   rate_in     in   WIDTH  new rate, sampled only while load=1
//   clear       in   1      restart phase, zero tick_count and square
//   tick        out  1      one-cycle pulse per rate+1 enabled cycles
//   square      out  1      toggles on every tick
//   tick_count  out  CNT_W  ticks since reset/clear, wraps silently
//   rate_q      out  WIDTH  currently active rate
// -----------------------------------------------------------------------------
module rate_tick_gen #(
  parameter int                WIDTH        = 28,
  parameter logic [WIDTH-1:0]  DEFAULT_RATE = WIDTH'(12_499_999),
  parameter int                CNT_W        = 8
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] rate_in,
  input  logic             clear,
  output logic             tick,
  output logic             square,
  output logic [CNT_W-1:0] tick_count,
  output logic [WIDTH-1:0] rate_q
);

  logic [WIDTH-1:0] r_rate;
  logic [WIDTH-1:0] r_counter;
  logic             r_tick;
  logic             r_square;
  logic [CNT_W-1:0] r_tick_count;

  // Counter reaching zero marks the last cycle of the current period.
  logic w_period_end;
  assign w_period_end = (r_counter == '0);

  // Only decrement and reload are ever applied to the counter, so any rate up
  // to the full register width works without overflow.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_rate       <= DEFAULT_RATE;
      r_counter    <= DEFAULT_RATE;
      r_tick       <= 1'b0;
      r_square     <= 1'b0;
      r_tick_count <= '0;
    end else if (clear) begin
      // Phase restart keeps the active rate; a coincident tick is dropped.
      r_counter    <= r_rate;
      r_tick       <= 1'b0;
      r_square     <= 1'b0;
      r_tick_count <= '0;
    end else if (load) begin
      // New rate takes effect immediately with a full period.
      r_rate    <= rate_in;
      r_counter <= rate_in;
      r_tick    <= 1'b0;
    end else if (enable) begin
      if (w_period_end) begin
        r_counter    <= r_rate;
        r_tick       <= 1'b1;
        r_square     <= ~r_square;
        r_tick_count <= r_tick_count + CNT_W'(1);
      end else begin
        r_counter <= r_counter - WIDTH'(1);
        r_tick    <= 1'b0;
      end
    end else begin
      // Paused: phase, square and count hold so counting resumes seamlessly.
      r_tick <= 1'b0;
    end
  end

  assign tick       = r_tick;
  assign square     = r_square;
  assign tick_count = r_tick_count;
  assign rate_q     = r_rate;

endmodule

// File: tb/tb_rate_tick_gen.sv
module tb_rate_tick_gen;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int DR = 9;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  rate_in = '0;
  logic          tick;
  logic          square;
  logic [CW-1:0] tick_count;
  logic [W-1:0]  rate_q;

  rate_tick_gen #(
    .WIDTH       (W),
    .DEFAULT_RATE(W'(DR)),
    .CNT_W       (CW)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .enable    (enable),
    .load      (load),
    .rate_in   (rate_in),
    .clear     (clear),
    .tick      (tick),
    .square    (square),
    .tick_count(tick_count),
    .rate_q    (rate_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts enabled edges since the phase last restarted and
  // fires when rate+1 of them have accumulated.
  int m_rate;
  int m_since;
  int m_cnt;
  bit m_tick;
  bit m_sq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rate  = DR;
    m_since = 0;
    m_cnt   = 0;
    m_tick  = 0;
    m_sq    = 0;
  endtask

  task automatic model_edge();
    if (!resetn) begin
      model_reset();
    end else if (clear) begin
      m_since = 0; m_tick = 0; m_sq = 0; m_cnt = 0;
    end else if (load) begin
      m_rate = int'(rate_in); m_since = 0; m_tick = 0;
    end else if (enable) begin
      m_since++;
      if (m_since == m_rate + 1) begin
        m_since = 0; m_tick = 1; m_sq = ~m_sq; m_cnt = (m_cnt + 1) % (1 << CW);
      end else begin
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"},       32'(tick),       32'(m_tick));
    chk({tag, ".square"},     32'(square),     32'(m_sq));
    chk({tag, ".tick_count"}, 32'(tick_count), 32'(m_cnt));
    chk({tag, ".rate_q"},     32'(rate_q),     32'(m_rate));
  endtask

  // One clock edge: model consumes the inputs seen at the edge, DUT outputs
  // are compared 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n, input bit en);
    enable = en; load = 0; clear = 0;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic do_load(input string tag, input int r, input bit en);
    load = 1; clear = 0; enable = en; rate_in = W'(r);
    cycle(tag);
    load = 0;
  endtask

  initial begin
    model_reset();
    // Asynchronous reset assertion between edges.
    #3 resetn = 0;
    #1 check_all("reset_async");
    cycle("reset_hold");
    cycle("reset_hold");
    resetn = 1;

    // First tick after DEFAULT_RATE+1 enabled edges.
    run("default_rate", 2 * (DR + 1) + 3, 1);

    // 1: rate 3 -> ticks every 4 cycles.
    do_load("load3", 3, 1);
    run("rate3", 16, 1);
    chk("rate3_count", 32'(tick_count), 32'(m_cnt));

    // 2: rate 0 -> tick every cycle.
    do_load("load0", 0, 1);
    run("rate0", 10, 1);

    // 3: rate 5, pause 7 cycles with counter at 2.
    do_load("load5", 5, 1);
    run("rate5_pre", 3, 1);
    run("rate5_pause", 7, 0);
    run("rate5_resume", 10, 1);

    // 4: load on the edge the counter hits 0 drops that tick.
    do_load("load3b", 3, 1);
    run("rate3b", 3, 1);
    do_load("load_collide", 1, 1);
    chk("load_collide_tick", 32'(tick), 32'd0);
    run("rate1", 8, 1);
    chk("rate1_rate_q", 32'(rate_q), 32'd1);

    // 5: clear together with a due tick.
    do_load("load4", 4, 1);
    run("rate4", 4, 1);
    clear = 1; enable = 1;
    cycle("clear_collide");
    clear = 0;
    chk("clear_tick", 32'(tick), 32'd0);
    chk("clear_count", 32'(tick_count), 32'd0);
    run("after_clear", 12, 1);

    // Holding load high pins the counter and suppresses ticks.
    load = 1; enable = 1; rate_in = W'(0);
    for (int i = 0; i < 5; i++) cycle("load_held");
    load = 0;
    clear = 1;
    for (int i = 0; i < 3; i++) cycle("clear_held");
    clear = 0;

    // 6: rate 0, 256 enabled cycles -> tick_count wraps back to 0.
    run("wrap", 256, 1);
    chk("wrap_zero", 32'(tick_count), 32'd0);

    // Max rate: no overflow, period of 2^W cycles.
    do_load("load_max", (1 << W) - 1, 1);
    run("rate_max", 2 * (1 << W) + 4, 1);

    // Randomized mix of enable/load/clear.
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 9) < 8);
      load    = ($urandom_range(0, 29) == 0);
      clear   = ($urandom_range(0, 39) == 0);
      rate_in = W'($urandom_range(0, 6));
      cycle("random");
    end
    load = 0; clear = 0;

    // Async reset mid-period, then full DEFAULT_RATE+1 to first tick.
    do_load("load6", 6, 1);
    run("pre_reset", 3, 1);
    @(negedge clk);
    resetn = 0;
    model_reset();
    #1 check_all("reset_mid");
    cycle("reset_mid_hold");
    resetn = 1;
    run("post_reset", 2 * (DR + 1) + 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
